// File: rtl/calc_control_n.sv
// Keypad sequencing FSM for the calculator datapath.
// All command pulses, counters and display select are registered.
module calc_control_n #(
  parameter int MAX_DIGITS = 4,
  parameter int DIG_CW     = 3,
  parameter bit CHAIN_EN   = 1'b1
) (
  input  logic              clock,
  input  logic              reset_in,
  input  logic              clr_in,
  input  logic              dig_in,
  input  logic              sub_in,
  input  logic              op_in,
  input  logic              ex_in,
  input  logic              bksp_in,
  input  logic              MR_in,
  input  logic              MS_in,
  input  logic              MC_in,
  input  logic              err_in,
  output logic              load_A,
  output logic              load_B,
  output logic              bksp_A,
  output logic              bksp_B,
  output logic              load_A_mem,
  output logic              load_B_mem,
  output logic              load_A_res,
  output logic              load_op,
  output logic              execute,
  output logic              load_mem,
  output logic              clear_mem,
  output logic              clear_ops,
  output logic [1:0]        disp_sel,
  output logic [DIG_CW-1:0] digits_A,
  output logic [DIG_CW-1:0] digits_B,
  output logic [2:0]        state_out
);

  typedef enum logic [2:0] {
    START    = 3'd0,
    OP_A     = 3'd1,
    OP_A_NEG = 3'd2,
    OPERATOR = 3'd3,
    OP_B     = 3'd4,
    OP_B_NEG = 3'd5,
    RESULT   = 3'd6,
    ERROR    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    K_NONE, K_CLR, K_EX, K_OP,
    K_SUB, K_DIG, K_MR, K_BKSP
  } key_t;

  localparam logic [DIG_CW-1:0] DMAX = DIG_CW'(MAX_DIGITS);
  localparam logic [DIG_CW-1:0] DONE = DIG_CW'(1);
  localparam logic [DIG_CW-1:0] DZRO = '0;

  state_t            state, state_d;
  key_t              key;
  logic [DIG_CW-1:0] cnt_a_d, cnt_b_d;
  logic              la_d, lb_d, ba_d, bb_d;
  logic              lam_d, lbm_d, lar_d, lop_d;
  logic              exe_d, lm_d, cm_d, co_d;
  logic [1:0]        disp_d;
  logic              rst_q;

  assign state_out = state;

  always_comb begin
    key = K_NONE;
    priority case (1'b1)
      clr_in:  key = K_CLR;
      ex_in:   key = K_EX;
      op_in:   key = K_OP;
      sub_in:  key = K_SUB;
      dig_in:  key = K_DIG;
      MR_in:   key = K_MR;
      bksp_in: key = K_BKSP;
      default: key = K_NONE;
    endcase
  end

  always_comb begin
    state_d = state;
    cnt_a_d = digits_A;
    cnt_b_d = digits_B;
    la_d    = 1'b0;
    lb_d    = 1'b0;
    ba_d    = 1'b0;
    bb_d    = 1'b0;
    lam_d   = 1'b0;
    lbm_d   = 1'b0;
    lar_d   = 1'b0;
    lop_d   = 1'b0;
    exe_d   = 1'b0;
    cm_d    = MC_in;
    lm_d    = MS_in && (state != ERROR);
    co_d    = rst_q;
    if (state == RESULT && err_in) begin
      // ALU fault wins over every key sampled alongside it
      state_d = ERROR;
      lm_d    = 1'b0;
    end else if (key == K_CLR) begin
      co_d    = 1'b1;
      cnt_a_d = DZRO;
      cnt_b_d = DZRO;
      state_d = START;
    end else begin
      case (state)
        START, OP_A_NEG: begin
          case (key)
            K_SUB, K_BKSP: begin
              if (state == START && key == K_SUB) begin
                la_d    = 1'b1;
                state_d = OP_A_NEG;
              end else if (state == OP_A_NEG) begin
                ba_d    = 1'b1;
                state_d = START;
              end
            end
            K_DIG: begin
              la_d    = 1'b1;
              cnt_a_d = DONE;
              state_d = OP_A;
            end
            K_MR: begin
              lam_d   = 1'b1;
              cnt_a_d = DMAX;
              state_d = OP_A;
            end
            default: ;
          endcase
        end
        OP_A: begin
          case (key)
            K_DIG: if (digits_A < DMAX) begin
              la_d    = 1'b1;
              cnt_a_d = digits_A + DONE;
            end
            K_BKSP: if (digits_A != DZRO) begin
              ba_d    = 1'b1;
              cnt_a_d = digits_A - DONE;
            end
            K_MR: begin
              lam_d   = 1'b1;
              cnt_a_d = DMAX;
            end
            K_OP, K_SUB: begin
              lop_d   = 1'b1;
              state_d = OPERATOR;
            end
            default: ;
          endcase
        end
        OPERATOR, OP_B_NEG: begin
          case (key)
            K_OP: if (state == OPERATOR) lop_d = 1'b1;
            K_SUB, K_BKSP: begin
              if (state == OPERATOR && key == K_SUB) begin
                lb_d    = 1'b1;
                state_d = OP_B_NEG;
              end else if (state == OP_B_NEG) begin
                bb_d    = 1'b1;
                state_d = OPERATOR;
              end
            end
            K_DIG: begin
              lb_d    = 1'b1;
              cnt_b_d = DONE;
              state_d = OP_B;
            end
            K_MR: begin
              lbm_d   = 1'b1;
              cnt_b_d = DMAX;
              state_d = OP_B;
            end
            default: ;
          endcase
        end
        OP_B: begin
          case (key)
            K_EX: begin
              exe_d   = 1'b1;
              state_d = RESULT;
            end
            K_DIG: if (digits_B < DMAX) begin
              lb_d    = 1'b1;
              cnt_b_d = digits_B + DONE;
            end
            K_BKSP: if (digits_B != DZRO) begin
              bb_d    = 1'b1;
              cnt_b_d = digits_B - DONE;
            end
            K_MR: begin
              lbm_d   = 1'b1;
              cnt_b_d = DMAX;
            end
            default: ;
          endcase
        end
        RESULT: begin
          if (key == K_OP && CHAIN_EN) begin
            lar_d   = 1'b1;
            lop_d   = 1'b1;
            cnt_a_d = DMAX;
            cnt_b_d = DZRO;
            state_d = OPERATOR;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    disp_d = 2'b00;
    case (state_d)
      START, OP_A, OP_A_NEG:    disp_d = 2'b00;
      OPERATOR, OP_B, OP_B_NEG: disp_d = 2'b01;
      RESULT:                   disp_d = 2'b10;
      default:                  disp_d = 2'b11;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_in) begin
      state      <= START;
      digits_A   <= DZRO;
      digits_B   <= DZRO;
      disp_sel   <= 2'b00;
      load_A     <= 1'b0;
      load_B     <= 1'b0;
      bksp_A     <= 1'b0;
      bksp_B     <= 1'b0;
      load_A_mem <= 1'b0;
      load_B_mem <= 1'b0;
      load_A_res <= 1'b0;
      load_op    <= 1'b0;
      execute    <= 1'b0;
      load_mem   <= 1'b0;
      clear_mem  <= 1'b0;
      clear_ops  <= 1'b0;
      rst_q      <= 1'b1;
    end else begin
      state      <= state_d;
      digits_A   <= cnt_a_d;
      digits_B   <= cnt_b_d;
      disp_sel   <= disp_d;
      load_A     <= la_d;
      load_B     <= lb_d;
      bksp_A     <= ba_d;
      bksp_B     <= bb_d;
      load_A_mem <= lam_d;
      load_B_mem <= lbm_d;
      load_A_res <= lar_d;
      load_op    <= lop_d;
      execute    <= exe_d;
      load_mem   <= lm_d;
      clear_mem  <= cm_d;
      clear_ops  <= co_d;
      rst_q      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_calc_control_n.sv
// Directed scoreboard bench for calc_control_n.
// A second instance with result chaining disabled shares the key inputs.
module tb_calc_control_n;

  logic clock = 1'b0;
  logic reset_in, clr_in, dig_in, sub_in, op_in, ex_in;
  logic bksp_in, MR_in, MS_in, MC_in, err_in;

  logic load_A, load_B, bksp_A, bksp_B, load_A_mem, load_B_mem;
  logic load_A_res, load_op, execute, load_mem, clear_mem, clear_ops;
  logic [1:0] disp_sel;
  logic [2:0] digits_A, digits_B, state_out;

  logic n_load_A, n_load_B, n_bksp_A, n_bksp_B, n_load_A_mem;
  logic n_load_B_mem, n_load_A_res, n_load_op, n_execute;
  logic n_load_mem, n_clear_mem, n_clear_ops;
  logic [1:0] n_disp_sel;
  logic [2:0] n_digits_A, n_digits_B, n_state_out;

  int checks = 0;
  int errors = 0;

  localparam logic [10:0] K_RST = 11'h400;
  localparam logic [10:0] K_ERR = 11'h200;
  localparam logic [10:0] K_CLR = 11'h100;
  localparam logic [10:0] K_DIG = 11'h080;
  localparam logic [10:0] K_SUB = 11'h040;
  localparam logic [10:0] K_OP  = 11'h020;
  localparam logic [10:0] K_EX  = 11'h010;
  localparam logic [10:0] K_BK  = 11'h008;
  localparam logic [10:0] K_MR  = 11'h004;
  localparam logic [10:0] K_MS  = 11'h002;
  localparam logic [10:0] K_MC  = 11'h001;

  localparam logic [11:0] P_LA  = 12'h800;
  localparam logic [11:0] P_LB  = 12'h400;
  localparam logic [11:0] P_BA  = 12'h200;
  localparam logic [11:0] P_BB  = 12'h100;
  localparam logic [11:0] P_LAM = 12'h080;
  localparam logic [11:0] P_LBM = 12'h040;
  localparam logic [11:0] P_LAR = 12'h020;
  localparam logic [11:0] P_LOP = 12'h010;
  localparam logic [11:0] P_EXE = 12'h008;
  localparam logic [11:0] P_LM  = 12'h004;
  localparam logic [11:0] P_CM  = 12'h002;
  localparam logic [11:0] P_CO  = 12'h001;

  typedef struct {
    logic [11:0] p;
    logic [2:0]  st;
    logic [1:0]  ds;
    logic [2:0]  da;
    logic [2:0]  db;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  calc_control_n #(.MAX_DIGITS(4), .DIG_CW(3), .CHAIN_EN(1'b1)) u_dut (
    .clock(clock), .reset_in(reset_in), .clr_in(clr_in),
    .dig_in(dig_in), .sub_in(sub_in), .op_in(op_in), .ex_in(ex_in),
    .bksp_in(bksp_in), .MR_in(MR_in), .MS_in(MS_in), .MC_in(MC_in),
    .err_in(err_in),
    .load_A(load_A), .load_B(load_B), .bksp_A(bksp_A),
    .bksp_B(bksp_B), .load_A_mem(load_A_mem),
    .load_B_mem(load_B_mem), .load_A_res(load_A_res),
    .load_op(load_op), .execute(execute), .load_mem(load_mem),
    .clear_mem(clear_mem), .clear_ops(clear_ops),
    .disp_sel(disp_sel), .digits_A(digits_A),
    .digits_B(digits_B), .state_out(state_out)
  );

  calc_control_n #(.MAX_DIGITS(4), .DIG_CW(3), .CHAIN_EN(1'b0)) u_dut0 (
    .clock(clock), .reset_in(reset_in), .clr_in(clr_in),
    .dig_in(dig_in), .sub_in(sub_in), .op_in(op_in), .ex_in(ex_in),
    .bksp_in(bksp_in), .MR_in(MR_in), .MS_in(MS_in), .MC_in(MC_in),
    .err_in(err_in),
    .load_A(n_load_A), .load_B(n_load_B), .bksp_A(n_bksp_A),
    .bksp_B(n_bksp_B), .load_A_mem(n_load_A_mem),
    .load_B_mem(n_load_B_mem), .load_A_res(n_load_A_res),
    .load_op(n_load_op), .execute(n_execute),
    .load_mem(n_load_mem), .clear_mem(n_clear_mem),
    .clear_ops(n_clear_ops), .disp_sel(n_disp_sel),
    .digits_A(n_digits_A), .digits_B(n_digits_B),
    .state_out(n_state_out)
  );

  function automatic logic [1:0] disp_of(input logic [2:0] st);
    if (st <= 3'd2) return 2'b00;
    if (st <= 3'd5) return 2'b01;
    if (st == 3'd6) return 2'b10;
    return 2'b11;
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs,
                     input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [10:0] k);
    reset_in = k[10];
    err_in   = k[9];
    clr_in   = k[8];
    dig_in   = k[7];
    sub_in   = k[6];
    op_in    = k[5];
    ex_in    = k[4];
    bksp_in  = k[3];
    MR_in    = k[2];
    MS_in    = k[1];
    MC_in    = k[0];
  endtask

  task automatic step(input string tag, input logic [10:0] k,
                      input logic [11:0] p, input logic [2:0] st,
                      input logic [2:0] da, input logic [2:0] db);
    exp_t e;
    logic [11:0] obs;
    drive(k);
    e.p  = p;
    e.st = st;
    e.ds = disp_of(st);
    e.da = da;
    e.db = db;
    sb.push_back(e);
    @(posedge clock);
    #1;
    drive(11'h000);
    e = sb.pop_front();
    obs = {load_A, load_B, bksp_A, bksp_B, load_A_mem, load_B_mem,
           load_A_res, load_op, execute, load_mem, clear_mem,
           clear_ops};
    chk({tag, ".pulses"}, obs, e.p);
    chk({tag, ".state"}, {9'd0, state_out}, {9'd0, e.st});
    chk({tag, ".disp"}, {10'd0, disp_sel}, {10'd0, e.ds});
    chk({tag, ".digA"}, {9'd0, digits_A}, {9'd0, e.da});
    chk({tag, ".digB"}, {9'd0, digits_B}, {9'd0, e.db});
  endtask

  initial begin
    logic [11:0] n_obs;
    drive(K_RST);
    step("rst0", K_RST, 12'h0, 3'd0, 3'd0, 3'd0);
    step("rst1", K_RST, 12'h0, 3'd0, 3'd0, 3'd0);
    step("rst_rel", 11'h0, P_CO, 3'd0, 3'd0, 3'd0);

    step("a_d1", K_DIG, P_LA, 3'd1, 3'd1, 3'd0);
    step("a_d2", K_DIG, P_LA, 3'd1, 3'd2, 3'd0);
    step("a_d3", K_DIG, P_LA, 3'd1, 3'd3, 3'd0);
    step("a_d4", K_DIG, P_LA, 3'd1, 3'd4, 3'd0);
    step("op1", K_OP, P_LOP, 3'd3, 3'd4, 3'd0);
    step("b_d1", K_DIG, P_LB, 3'd4, 3'd4, 3'd1);
    step("b_d2", K_DIG, P_LB, 3'd4, 3'd4, 3'd2);
    step("exe", K_EX, P_EXE, 3'd6, 3'd4, 3'd2);

    step("chain", K_OP, P_LAR | P_LOP, 3'd3, 3'd4, 3'd0);
    n_obs = {n_load_A, n_load_B, n_bksp_A, n_bksp_B, n_load_A_mem,
             n_load_B_mem, n_load_A_res, n_load_op, n_execute,
             n_load_mem, n_clear_mem, n_clear_ops};
    chk("nochain.pulses", n_obs, 12'h0);
    chk("nochain.state", {9'd0, n_state_out}, 12'd6);
    chk("nochain.disp", {10'd0, n_disp_sel}, 12'd2);
    chk("nochain.digB", {9'd0, n_digits_B}, 12'd2);
    step("clr1", K_CLR, P_CO, 3'd0, 3'd0, 3'd0);

    for (int i = 1; i <= 4; i++)
      step("sat_d", K_DIG, P_LA, 3'd1, 3'(i), 3'd0);
    step("sat_d5", K_DIG, 12'h0, 3'd1, 3'd4, 3'd0);
    step("sat_d6", K_DIG, 12'h0, 3'd1, 3'd4, 3'd0);
    for (int i = 3; i >= 0; i--)
      step("bk", K_BK, P_BA, 3'd1, 3'(i), 3'd0);
    step("bk5", K_BK, 12'h0, 3'd1, 3'd0, 3'd0);

    step("prio", K_OP | K_DIG | K_MS, P_LOP | P_LM, 3'd3, 3'd0, 3'd0);
    step("b_neg", K_SUB, P_LB, 3'd5, 3'd0, 3'd0);
    step("b_unneg", K_SUB, P_BB, 3'd3, 3'd0, 3'd0);
    step("clr2", K_CLR, P_CO, 3'd0, 3'd0, 3'd0);
    step("a_neg", K_SUB, P_LA, 3'd2, 3'd0, 3'd0);
    step("a_unneg", K_SUB, P_BA, 3'd0, 3'd0, 3'd0);

    step("e_d", K_DIG, P_LA, 3'd1, 3'd1, 3'd0);
    step("e_op", K_OP, P_LOP, 3'd3, 3'd1, 3'd0);
    step("e_db", K_DIG, P_LB, 3'd4, 3'd1, 3'd1);
    step("e_ex", K_EX, P_EXE, 3'd6, 3'd1, 3'd1);
    step("e_err", K_ERR, 12'h0, 3'd7, 3'd1, 3'd1);
    step("e_dig", K_DIG, 12'h0, 3'd7, 3'd1, 3'd1);
    step("e_ms", K_MS, 12'h0, 3'd7, 3'd1, 3'd1);
    step("e_mc", K_MC, P_CM, 3'd7, 3'd1, 3'd1);
    step("e_clr", K_CLR, P_CO, 3'd0, 3'd0, 3'd0);

    step("r_d", K_DIG, P_LA, 3'd1, 3'd1, 3'd0);
    step("r_op", K_OP, P_LOP, 3'd3, 3'd1, 3'd0);
    step("r_b1", K_DIG, P_LB, 3'd4, 3'd1, 3'd1);
    step("r_b2", K_DIG, P_LB, 3'd4, 3'd1, 3'd2);
    step("r_rst", K_RST | K_DIG, 12'h0, 3'd0, 3'd0, 3'd0);
    step("r_rel", 11'h0, P_CO, 3'd0, 3'd0, 3'd0);

    step("mr", K_MR, P_LAM, 3'd1, 3'd4, 3'd0);
    step("mr_dig", K_DIG, 12'h0, 3'd1, 3'd4, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_control_n.md
# calc_control_n

Parametrised successor to the calculator's keypad control FSM. Sits between the debounced key-strobe decoder and the operand, memory and ALU datapath. It sequences operand A entry, operator selection, operand B entry and result display, and emits registered one-cycle command pulses. Over the previous generation it adds:

- per-operand digit counting with a `MAX_DIGITS` limit;
- result chaining into the next operation;
- an ALU error state;
- a defined key-priority order.

## Interface
Parameters:
- `MAX_DIGITS`, 4: maximum digits per operand; further digit keys are ignored.
- `DIG_CW`, 3: digit-counter width; must satisfy 2^`DIG_CW` > `MAX_DIGITS`.
- `CHAIN_EN`, 1: 1 = an operator key in RESULT chains the result into operand A.

Ports:
- `clock`  in  1  single system clock; all state changes on the rising edge.
- `reset_in`  in  1  synchronous, active-high reset.
- `clr_in`, `dig_in`, `sub_in`, `op_in`, `ex_in`, `bksp_in`, `MR_in`, `MS_in`, `MC_in`  in  1 each  key strobes, each high for one cycle per press.
- `err_in`  in  1  ALU error flag (overflow or divide-by-zero); valid while in RESULT.
- `load_A`, `load_B`  out  1 each  shift digit or sign into the operand.
- `bksp_A`, `bksp_B`  out  1 each  remove the last digit or sign.
- `load_A_mem`, `load_B_mem`  out  1 each  copy memory into the operand.
- `load_A_res`  out  1  copy the result into operand A (chaining).
- `load_op`  out  1  latch the operator.
- `execute`  out  1  start the ALU.
- `load_mem`, `clear_mem`  out  1 each  memory store / memory clear.
- `clear_ops`  out  1  clear operands A and B and the operator.
- `disp_sel`  out  2  display source.
- `digits_A`, `digits_B`  out  `DIG_CW` each  digits currently entered.
- `state_out`  out  3  current state encoding.

## Operation
States and encodings: START=0, OP_A=1, OP_A_NEG=2, OPERATOR=3, OP_B=4, OP_B_NEG=5, RESULT=6, ERROR=7.

Key priority: at most one state-affecting key is acted on per cycle, chosen in this order: `clr_in` > `ex_in` > `op_in` > `sub_in` > `dig_in` > `MR_in` > `bksp_in`. `MS_in` and `MC_in` are independent of this priority.

Global rules:
- `clr_in` in any state: pulse `clear_ops`, zero both counters, go to START.
- `MC_in` in any state: pulse `clear_mem`.
- `MS_in` in any state except ERROR: pulse `load_mem`.

START:
- `sub_in`: pulse `load_A` (sign entry), go to OP_A_NEG.
- `dig_in`: pulse `load_A`, set `digits_A`=1, go to OP_A.
- `MR_in`: pulse `load_A_mem`, set `digits_A`=`MAX_DIGITS`, go to OP_A.

OP_A:
- `dig_in`: if `digits_A` < `MAX_DIGITS`, pulse `load_A` and increment; otherwise ignore.
- `bksp_in`: if `digits_A` > 0, pulse `bksp_A` and decrement; otherwise ignore.
- `MR_in`: behaves as in START, staying in OP_A.
- `op_in` or `sub_in`: pulse `load_op`, go to OPERATOR.

OP_A_NEG:
- `sub_in` or `bksp_in`: pulse `bksp_A`, go to START.
- `dig_in` or `MR_in`: behaves as in START, going to OP_A.

OPERATOR:
- `op_in`: pulse `load_op` (replaces the operator), stay.
- `sub_in`: pulse `load_B` (sign entry), go to OP_B_NEG.
- `dig_in` or `MR_in`: behaves as the OP_A entry rules, targeting B, go to OP_B.

OP_B and OP_B_NEG: mirror OP_A and OP_A_NEG, targeting B. OP_B_NEG backs out to OPERATOR, not START. Additionally:
- `ex_in` in OP_B: pulse `execute`, go to RESULT.
- `ex_in` in OP_B_NEG: ignored.

RESULT:
- `err_in`=1: go to ERROR with no pulses; this takes precedence over keys in the same cycle.
- `op_in` with `CHAIN_EN`=1: pulse `load_A_res` and `load_op` together, set `digits_A`=`MAX_DIGITS`, `digits_B`=0, go to OPERATOR.
- `dig_in`, `sub_in`, `bksp_in`, `MR_in`: ignored.

ERROR: only `clr_in` or `reset_in` leaves. All load, backspace and execute pulses are suppressed; `clear_mem` still works.

`disp_sel` by state: 00 in START, OP_A and OP_A_NEG; 01 in OPERATOR, OP_B and OP_B_NEG; 10 in RESULT; 11 in ERROR.

## Timing
- A strobe sampled at edge N produces its pulse(s), the new state, `disp_sel` and counter values, all valid from edge N through edge N+1.
- Pulses last exactly one cycle and are fully registered, with no combinational path from inputs to outputs.
- A key held high for k cycles is acted on k times; upstream guarantees one-cycle strobes.
- `reset_in` takes effect at the next edge, overrides all keys, and is honoured mid-entry:
  - state=START, all pulses 0, `disp_sel`=00, both counters 0, `state_out`=0;
  - `clear_ops`=1 for the first cycle after `reset_in` deasserts.
- `err_in` is first sampled the cycle after `execute` and on every cycle spent in RESULT.
- Counters saturate at 0 and `MAX_DIGITS`; they never wrap.

## Test plan
- Reset, then 4×`dig_in`, `op_in`, 2×`dig_in`, `ex_in` with `MAX_DIGITS`=4:
  - 4 `load_A` pulses, then `load_op`, then 2 `load_B`, then `execute`;
  - `disp_sel` sequence 00→01→10, `digits_A`=4, `digits_B`=2.
- 6×`dig_in` in OP_A: exactly 4 `load_A` pulses, `digits_A` stays 4. Then 5×`bksp_in`: exactly 4 `bksp_A` pulses, `digits_A`=0.
- `sub_in` then `sub_in` in START: `load_A` pulse, state 2, then `bksp_A` pulse, state 0. Repeat from OPERATOR: `load_B` pulse, then `bksp_B` pulse, state returns to 3.
- RESULT with `CHAIN_EN`=1, `op_in`: `load_A_res` and `load_op` high in the same cycle, state=3, `digits_A`=4. Same stimulus with `CHAIN_EN`=0: no pulse, state stays 6.
- `err_in`=1 in the cycle after `execute`: state=7, `disp_sel`=11. In ERROR:
  - `dig_in`, `MS_in` produce no pulse;
  - `MC_in` pulses `clear_mem`;
  - `clr_in` pulses `clear_ops` and goes to state 0.
- `op_in`+`dig_in`+`MS_in` together in OP_A: `load_op` and `load_mem` pulse, no `load_A`. `reset_in` mid-OP_B: next cycle state=0, counters 0, all pulses 0.
